// File: rtl/tts_pkg.sv
// Shared types and constants for the host read-response transmitter.
package tts_pkg;

  typedef enum logic [7:0] {
    RamSrcb = 8'h01,
    RamPrcb = 8'h02,
    RamVrcb = 8'h04,
    RamOrcb = 8'h08
  } t_RAM_ENCODING;

  localparam logic [7:0]  RSP_RD         = 8'h81;
  localparam logic [7:0]  RSP_ERR        = 8'hE1;
  localparam int unsigned HOST_MSG_BYTES = 32;

  typedef struct packed {
    logic [7:0]   cmd;
    logic [7:0]   ram;
    logic [15:0]  addr;
    logic [7:0]   res;
    logic [23:0]  byte_en;
    logic [191:0] data;
  } t_host_rsp;

  // Zero result marks an encoding that is not exactly one legal RAM.
  function automatic logic [3:0] ram_to_strobe(input logic [7:0] ram);
    case (ram)
      RamSrcb: return 4'b0001;
      RamPrcb: return 4'b0010;
      RamVrcb: return 4'b0100;
      RamOrcb: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/tts_host_rsp_tx_if.sv
// Request, RCB read and response-beat signals of tts_host_rsp_tx.
// Optional tx_par is present when TTS_RSP_PARITY_EN is defined.
interface tts_host_rsp_tx_if;
  logic         req_valid;
  logic         req_ready;
  logic [7:0]   req_ram;
  logic [15:0]  req_addr;
  logic [3:0]   rcb_rd_en;
  logic [15:0]  rcb_rd_addr;
  logic [191:0] rcb_rd_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [63:0]  tx_data;
  logic         tx_sop;
  logic         tx_eop;
`ifdef TTS_RSP_PARITY_EN
  logic [7:0]   tx_par;
`endif

  modport master (
    output req_valid, req_ram, req_addr, rcb_rd_data, tx_ready,
    input  req_ready, rcb_rd_en, rcb_rd_addr, tx_valid, tx_data, tx_sop, tx_eop
`ifdef TTS_RSP_PARITY_EN
    , input tx_par
`endif
  );

  modport slave (
    input  req_valid, req_ram, req_addr, rcb_rd_data, tx_ready,
    output req_ready, rcb_rd_en, rcb_rd_addr, tx_valid, tx_data, tx_sop, tx_eop
`ifdef TTS_RSP_PARITY_EN
    , output tx_par
`endif
  );
endinterface

// File: rtl/tts_rsp_serializer.sv
// Loads one 256-bit host message and shifts it out MSB-first as four
// 64-bit valid/ready beats with sop on the first and eop on the last.
module tts_rsp_serializer
  import tts_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [HOST_MSG_BYTES*8-1:0] msg,
  output logic                        valid,
  input  logic                        ready,
  output logic [63:0]                 data,
  output logic                        sop,
  output logic                        eop
);

  logic         valid_q, sop_q, eop_q;
  logic [63:0]  data_q;
  logic [191:0] rest_q;
  logic [1:0]   beat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      data_q  <= '0;
      rest_q  <= '0;
      beat_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      sop_q   <= 1'b1;
      eop_q   <= 1'b0;
      data_q  <= msg[255:192];
      rest_q  <= msg[191:0];
      beat_q  <= '0;
    end else if (valid_q && ready) begin
      sop_q <= 1'b0;
      if (eop_q) begin
        valid_q <= 1'b0;
        eop_q   <= 1'b0;
        data_q  <= '0;
      end else begin
        data_q <= rest_q[191:128];
        rest_q <= {rest_q[127:0], 64'h0};
        beat_q <= beat_q + 2'd1;
        eop_q  <= (beat_q == 2'd2);
      end
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign sop   = sop_q;
  assign eop   = eop_q;

endmodule

// File: rtl/tts_host_rsp_tx.sv
// Host read-response transmitter: reads one RCB word, frames it as a 256-bit
// host message, sends it as 4 beats. Optional tx_par via TTS_RSP_PARITY_EN.
module tts_host_rsp_tx
  import tts_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  tts_host_rsp_tx_if.slave  bus,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {StIdle, StRdWait, StSend} state_e;

  localparam logic [2:0] LatCnt = 3'(RD_LAT);

  state_e       state_q;
  logic [2:0]   cnt_q;
  logic [3:0]   rd_en_q;
  logic [15:0]  rd_addr_q;
  logic [7:0]   ram_q;
  logic [15:0]  addr_q;
  logic         bad_q;
  logic [191:0] data_q;
  logic [7:0]   err_cnt_q;
  logic         load_q;
  logic [3:0]   strobe;
  t_host_rsp    msg;

  assign strobe = ram_to_strobe(bus.req_ram);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rd_en_q   <= '0;
      rd_addr_q <= '0;
      ram_q     <= '0;
      addr_q    <= '0;
      bad_q     <= 1'b0;
      data_q    <= '0;
      err_cnt_q <= '0;
      load_q    <= 1'b0;
    end else begin
      rd_en_q <= '0;
      load_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            ram_q  <= bus.req_ram;
            addr_q <= bus.req_addr;
            data_q <= '0;
            if (|strobe) begin
              rd_en_q   <= strobe;
              rd_addr_q <= bus.req_addr;
              cnt_q     <= '0;
              bad_q     <= 1'b0;
              state_q   <= StRdWait;
            end else begin
              bad_q   <= 1'b1;
              load_q  <= 1'b1;
              state_q <= StSend;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
          end
        end
        StRdWait: begin
          // cnt_q reaches RD_LAT on the edge where read data is valid
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == LatCnt) begin
            data_q  <= bus.rcb_rd_data;
            load_q  <= 1'b1;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (bus.tx_valid && bus.tx_ready && bus.tx_eop) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    msg         = '0;
    msg.cmd     = bad_q ? RSP_ERR : RSP_RD;
    msg.ram     = ram_q;
    msg.addr    = addr_q;
    msg.byte_en = bad_q ? 24'h0 : 24'hFFFFFF;
    msg.data    = data_q;
  end

  tts_rsp_serializer u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_q),
    .msg   (msg),
    .valid (bus.tx_valid),
    .ready (bus.tx_ready),
    .data  (bus.tx_data),
    .sop   (bus.tx_sop),
    .eop   (bus.tx_eop)
  );

  // Gated by rst_n so ready reads low throughout reset yet high straight after.
  assign bus.req_ready   = rst_n && (state_q == StIdle);
  assign bus.rcb_rd_en   = rd_en_q;
  assign bus.rcb_rd_addr = rd_addr_q;
  assign err_cnt         = err_cnt_q;

`ifdef TTS_RSP_PARITY_EN
  always_comb begin
    bus.tx_par = '0;
    for (int i = 0; i < 8; i++) bus.tx_par[i] = ^bus.tx_data[8*i +: 8];
  end
`endif

endmodule

// File: tb/tb_tts_host_rsp_tx.sv
// Scoreboard bench for tts_host_rsp_tx: expected beats and read strobes are
// queued when a request is driven and compared as the DUT produces them.
module tb_tts_host_rsp_tx;

  localparam int unsigned RD_LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] err_cnt;

  tts_host_rsp_tx_if bus ();

  tts_host_rsp_tx #(.RD_LAT(RD_LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // RCB model: returns the word RD_LAT cycles after the strobe, garbage otherwise.
  logic [191:0] ram_word = '0;
  logic [3:0]   rd_pipe;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pipe <= '0;
    else        rd_pipe <= {rd_pipe[2:0], |bus.rcb_rd_en};
  end
  assign bus.rcb_rd_data = rd_pipe[RD_LAT-1] ? ram_word : ~ram_word;

  logic rand_rdy = 1'b0;
  always @(posedge clk) begin
    #2;
    bus.tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [65:0] exp_q[$];
  logic [19:0] rd_q[$];
  int          cyc = 0;
  int          beats_seen = 0;
  int          sop_cyc = 0;
  int          eop_cyc = 0;
  logic [63:0] last_sop = '0;
  logic        stall_pend = 1'b0;
  logic [65:0] stall_word = '0;

  always @(negedge clk) begin
    logic [65:0] e;
    logic [19:0] r;
    cyc++;
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend && bus.tx_valid)
        check_eq("stall_hold", {bus.tx_sop, bus.tx_eop, bus.tx_data}, stall_word);
      stall_pend = 1'b0;
      if (bus.tx_valid && !bus.tx_ready) begin
        stall_pend = 1'b1;
        stall_word = {bus.tx_sop, bus.tx_eop, bus.tx_data};
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("beat_unexpected", bus.tx_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_eq("beat", {bus.tx_sop, bus.tx_eop, bus.tx_data}, e);
`ifdef TTS_RSP_PARITY_EN
          begin
            logic [7:0] p;
            for (int i = 0; i < 8; i++) p[i] = ^e[8*i +: 8];
            check_eq("parity", bus.tx_par, p);
          end
`endif
          beats_seen++;
          if (bus.tx_sop) begin
            sop_cyc  = cyc;
            last_sop = bus.tx_data;
          end
          if (bus.tx_eop) eop_cyc = cyc;
        end
      end
      if (|bus.rcb_rd_en) begin
        if (rd_q.size() == 0) begin
          check_eq("rd_unexpected", bus.rcb_rd_en, 4'b0000);
        end else begin
          r = rd_q.pop_front();
          check_eq("rd_strobe", {bus.rcb_rd_en, bus.rcb_rd_addr}, r);
        end
      end
    end
  end

  task automatic send_req(input logic [7:0] ram, input logic [15:0] addr,
                          input logic [191:0] word);
    int          n = 0;
    logic        legal;
    logic [3:0]  strobe;
    logic [255:0] m;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_ready", bus.req_ready, 1'b1);
    ram_word = word;
    strobe = (ram == 8'h01) ? 4'b0001 : (ram == 8'h02) ? 4'b0010 :
             (ram == 8'h04) ? 4'b0100 : (ram == 8'h08) ? 4'b1000 : 4'b0000;
    legal = (strobe != 4'b0000);
    m = {legal ? 8'h81 : 8'hE1, ram, addr, 8'h00,
         legal ? 24'hFFFFFF : 24'h0, legal ? word : 192'h0};
    exp_q.push_back({1'b1, 1'b0, m[255:192]});
    exp_q.push_back({1'b0, 1'b0, m[191:128]});
    exp_q.push_back({1'b0, 1'b0, m[127:64]});
    exp_q.push_back({1'b0, 1'b1, m[63:0]});
    if (legal) rd_q.push_back({strobe, addr});
    bus.req_valid = 1'b1;
    bus.req_ram   = ram;
    bus.req_addr  = addr;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
    check_eq("rd_drain", rd_q.size(), 0);
  endtask

  function automatic logic [191:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [7:0] bad_rams[8];

  initial begin
    int n;
    int base;
    bad_rams = '{8'h00, 8'h03, 8'h05, 8'h06, 8'h09, 8'h10, 8'h0F, 8'hFF};
    bus.req_valid = 1'b0;
    bus.req_ram   = '0;
    bus.req_addr  = '0;
    bus.tx_ready  = 1'b1;

    #12;
    check_eq("rst_req_ready", bus.req_ready, 1'b0);
    check_eq("rst_rd_en", bus.rcb_rd_en, 4'b0000);
    check_eq("rst_tx_valid", bus.tx_valid, 1'b0);
    check_eq("rst_sop_eop", {bus.tx_sop, bus.tx_eop}, 2'b00);
    check_eq("rst_tx_data", bus.tx_data, 64'h0);
    check_eq("rst_err_cnt", err_cnt, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("post_rst_ready", bus.req_ready, 1'b1);

    // Good read from PRCB with ready held high: four consecutive beats.
    send_req(8'h02, 16'h0010, {24{8'hA5}});
    wait_drain();
    check_eq("good_beat0", last_sop, 64'h81020010_00FFFFFF);
    check_eq("beat_span", eop_cyc - sop_cyc, 3);

    // Illegal RAM encoding.
    check_eq("err_cnt_before", err_cnt, 8'd0);
    send_req(8'h03, 16'h0000, rand_word());
    wait_drain();
    check_eq("err_beat0", last_sop, 64'hE1030000_00000000);
    check_eq("err_cnt_after", err_cnt, 8'd1);

    send_req(8'h01, 16'h1234, rand_word());
    wait_drain();
    send_req(8'h04, 16'hFFFF, rand_word());
    wait_drain();
    send_req(8'h08, 16'h8001, rand_word());
    wait_drain();

    // Random backpressure.
    rand_rdy = 1'b1;
    send_req(8'h02, 16'h0010, {24{8'hA5}});
    wait_drain();
    check_eq("stall_beat0", last_sop, 64'h81020010_00FFFFFF);
    for (int i = 0; i < 6; i++) begin
      send_req((i % 2 == 0) ? 8'h04 : 8'h07, 16'($urandom), rand_word());
      wait_drain();
    end
    rand_rdy = 1'b0;

    // Saturation of the bad-request counter.
    for (int i = 0; i < 256; i++) begin
      send_req(bad_rams[i % 8], 16'(i), rand_word());
      wait_drain();
    end
    check_eq("err_cnt_sat", err_cnt, 8'd255);
    send_req(8'h00, 16'h0042, rand_word());
    wait_drain();
    check_eq("err_cnt_hold", err_cnt, 8'd255);

    // Reset after beat1 has transferred.
    base = beats_seen;
    send_req(8'h02, 16'h0123, rand_word());
    n = 0;
    while (beats_seen < base + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_beat1", beats_seen - base, 2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_tx_valid", bus.tx_valid, 1'b0);
    check_eq("midrst_eop", bus.tx_eop, 1'b0);
    check_eq("midrst_req_ready", bus.req_ready, 1'b0);
    check_eq("midrst_tx_data", bus.tx_data, 64'h0);
    check_eq("midrst_err_cnt", err_cnt, 8'h00);
    exp_q.delete();
    rd_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("midrst_release_ready", bus.req_ready, 1'b1);
    send_req(8'h08, 16'hBEEF, rand_word());
    wait_drain();
    check_eq("after_rst_beat0", last_sop, 64'h0808BEEF_00FFFFFF ^ 64'h8900000000000000);

    repeat (5) @(negedge clk);
    check_eq("final_exp_q", exp_q.size(), 0);
    check_eq("final_rd_q", rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
